// File: rtl/fifo_tx_drain_pkg.sv
// Shared types and helpers for the FIFO-to-UART drain block.
// State encoding and timer sizing live here.
package fifo_tx_drain_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  function automatic int timer_width(input int ack, input int gap);
    int m;
    m = (ack > gap) ? ack : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/fifo_tx_drain_if.sv
// FIFO read side plus UART TX request/busy bundle.
// master = drain block, slave = FIFO/UART side.
interface fifo_tx_drain_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  FIFO_EMPTY;
  logic [DATA_WIDTH-1:0] FIFO_RD_DATA;
  logic                  FIFO_R_INC;
  logic                  TX_BUSY;
  logic [DATA_WIDTH-1:0] TX_P_DATA;
  logic                  TX_DATA_VALID;

  modport master (
    input  FIFO_EMPTY,
    input  FIFO_RD_DATA,
    output FIFO_R_INC,
    input  TX_BUSY,
    output TX_P_DATA,
    output TX_DATA_VALID
  );

  modport slave (
    output FIFO_EMPTY,
    output FIFO_RD_DATA,
    input  FIFO_R_INC,
    output TX_BUSY,
    input  TX_P_DATA,
    input  TX_DATA_VALID
  );
endinterface

// File: rtl/fifo_tx_drain_cycle_timer.sv
// Loadable down-counter shared by the ack wait and the frame gap.
// Saturates at zero; zero flag is combinational from the count.
module fifo_tx_drain_cycle_timer #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/fifo_tx_drain.sv
// Pops bytes from the async FIFO read side and feeds the UART TX,
// with optional inter-frame gap and an ack timeout flag.
module fifo_tx_drain
  import fifo_tx_drain_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int GAP_CYCLES  = 0,
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 ERR_CLR,
  fifo_tx_drain_if.master      bus,
  output logic                 TIMEOUT_ERR,
  output logic [CNT_WIDTH-1:0] FRAME_CNT
);

  localparam int TW = timer_width(ACK_TIMEOUT, GAP_CYCLES);
  // Loaded with N-1 so the cycle that sees zero is the Nth one.
  localparam logic [TW-1:0] ACK_LOAD = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LOAD =
    TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] data_q, data_nx;
  logic [DATA_WIDTH-1:0] pdata_nx;
  logic                  rinc_nx;
  logic                  valid_nx;
  logic                  err_nx;
  logic [CNT_WIDTH-1:0]  cnt_nx;

  logic          t_load;
  logic          t_dec;
  logic          t_zero;
  logic [TW-1:0] t_val;

  fifo_tx_drain_cycle_timer #(
    .WIDTH(TW)
  ) cycle_timer (
    .clk  (CLK),
    .rst  (RST),
    .load (t_load),
    .value(t_val),
    .dec  (t_dec),
    .zero (t_zero)
  );

  always_comb begin
    state_nx = state;
    data_nx  = data_q;
    pdata_nx = bus.TX_P_DATA;
    rinc_nx  = 1'b0;
    valid_nx = 1'b0;
    err_nx   = TIMEOUT_ERR & ~ERR_CLR;
    cnt_nx   = FRAME_CNT;
    t_load   = 1'b0;
    t_val    = ACK_LOAD;
    t_dec    = 1'b0;
    unique case (state)
      IDLE: begin
        if (EN && !bus.FIFO_EMPTY && !bus.TX_BUSY) begin
          data_nx  = bus.FIFO_RD_DATA;
          rinc_nx  = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        valid_nx = 1'b1;
        pdata_nx = data_q;
        t_load   = 1'b1;
        t_val    = ACK_LOAD;
        state_nx = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.TX_BUSY) begin
          state_nx = WAIT_DONE;
        end else if (t_zero) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          t_dec = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.TX_BUSY) begin
          cnt_nx = FRAME_CNT + CNT_WIDTH'(1);
          if (GAP_CYCLES > 0) begin
            t_load   = 1'b1;
            t_val    = GAP_LOAD;
            state_nx = GAP;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      GAP: begin
        if (t_zero) begin
          state_nx = IDLE;
        end else begin
          t_dec = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state             <= IDLE;
      data_q            <= '0;
      bus.FIFO_R_INC    <= 1'b0;
      bus.TX_DATA_VALID <= 1'b0;
      bus.TX_P_DATA     <= '0;
      TIMEOUT_ERR       <= 1'b0;
      FRAME_CNT         <= '0;
    end else begin
      state             <= state_nx;
      data_q            <= data_nx;
      bus.FIFO_R_INC    <= rinc_nx;
      bus.TX_DATA_VALID <= valid_nx;
      bus.TX_P_DATA     <= pdata_nx;
      TIMEOUT_ERR       <= err_nx;
      FRAME_CNT         <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_fifo_tx_drain.sv
// Bench for fifo_tx_drain: queue-based FIFO and UART TX models,
// randomized bytes and busy lengths, directed scenario sequence.
module tb_fifo_tx_drain;

  localparam int DW  = 8;
  localparam int GAP = 4;
  localparam int ACK = 8;
  localparam int CW  = 2;

  logic          CLK;
  logic          RST;
  logic          EN;
  logic          ERR_CLR;
  logic          err;
  logic [CW-1:0] cnt;

  fifo_tx_drain_if #(.DATA_WIDTH(DW)) bus ();

  fifo_tx_drain #(
    .DATA_WIDTH (DW),
    .GAP_CYCLES (GAP),
    .ACK_TIMEOUT(ACK),
    .CNT_WIDTH  (CW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .ERR_CLR    (ERR_CLR),
    .bus        (bus),
    .TIMEOUT_ERR(err),
    .FRAME_CNT  (cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests  = 0;
  int failed = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got[$];

  int cyc = 0;
  int pops, seq_err, first_valid, err_rise, fall_cyc;
  int min_gap, max_gap;
  bit tx_ack, rand_busy, arm, prev_rinc, prev_err;
  int busy_len, busy_left;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_fifo();
    bus.FIFO_EMPTY   = (fifo_q.size() == 0);
    bus.FIFO_RD_DATA = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic push(input logic [DW-1:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    set_fifo();
  endtask

  task automatic tick();
    int d;
    @(posedge CLK);
    #1;
    cyc++;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        bus.TX_BUSY = 1'b0;
        fall_cyc = cyc;
      end
    end
    if (arm) begin
      arm = 1'b0;
      bus.TX_BUSY = 1'b1;
      busy_left = rand_busy ? $urandom_range(1, 10) : busy_len;
    end
    if (bus.TX_DATA_VALID !== prev_rinc) seq_err++;
    if (bus.FIFO_R_INC && prev_rinc) seq_err++;
    if (bus.TX_DATA_VALID) begin
      got.push_back(bus.TX_P_DATA);
      if (first_valid < 0) first_valid = cyc;
      if (tx_ack) arm = 1'b1;
    end
    if (err && !prev_err && err_rise < 0) err_rise = cyc;
    if (bus.FIFO_R_INC) begin
      pops++;
      if (fifo_q.size() == 0) seq_err++;
      else void'(fifo_q.pop_front());
      if (fall_cyc >= 0) begin
        d = cyc - fall_cyc;
        if (d < min_gap) min_gap = d;
        if (d > max_gap) max_gap = d;
        fall_cyc = -1;
      end
    end
    prev_rinc = bus.FIFO_R_INC;
    prev_err  = err;
    set_fifo();
  endtask

  task automatic start_scn();
    pops = 0;
    seq_err = 0;
    first_valid = -1;
    err_rise = -1;
    fall_cyc = -1;
    min_gap = 1000;
    max_gap = 0;
    got.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    arm = 1'b0;
    busy_left = 0;
    bus.TX_BUSY = 1'b0;
    fifo_q.delete();
    set_fifo();
    repeat (2) tick();
    RST = 1'b0;
    prev_rinc = 1'b0;
    start_scn();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || bus.TX_BUSY || arm) && n < 600) begin
      tick();
      n++;
    end
    check({tag, "_bound"}, 32'(n < 600), 1);
    repeat (30) tick();
  endtask

  task automatic check_order(input string tag);
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check({tag, "_byte"}, got[i], exp_q[i]);
  endtask

  initial begin
    int n;
    RST = 1'b1;
    EN = 1'b0;
    ERR_CLR = 1'b0;
    tx_ack = 1'b1;
    rand_busy = 1'b0;
    busy_len = 10;
    arm = 1'b0;
    busy_left = 0;
    prev_rinc = 1'b0;
    prev_err = 1'b0;
    bus.TX_BUSY = 1'b0;
    set_fifo();
    start_scn();

    // reset then idle
    do_reset();
    check("rst_rinc", bus.FIFO_R_INC, 0);
    check("rst_valid", bus.TX_DATA_VALID, 0);
    check("rst_pdata", bus.TX_P_DATA, 0);
    check("rst_err", err, 0);
    check("rst_cnt", cnt, 0);
    EN = 1'b1;
    repeat (20) tick();
    check("idle_pops", pops, 0);

    // single byte
    busy_len = 10;
    push(8'hA5);
    drain("single");
    check("single_pops", pops, 1);
    check_order("single");
    check("single_cnt", cnt, 1);
    check("single_seq", seq_err, 0);

    // burst with gap
    do_reset();
    busy_len = 8;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    drain("burst");
    check_order("burst");
    check("burst_cnt", cnt, 3);
    check("burst_gap_min", 32'(min_gap >= GAP + 1), 1);
    check("burst_gap_max", 32'(max_gap <= GAP + 2), 1);
    check("burst_seq", seq_err, 0);

    // busy already high in idle, then random bytes wrapping the counter
    do_reset();
    rand_busy = 1'b1;
    bus.TX_BUSY = 1'b1;
    push(8'($urandom));
    repeat (10) tick();
    check("busy_idle_pops", pops, 0);
    bus.TX_BUSY = 1'b0;
    for (int i = 0; i < 4; i++) push(8'($urandom));
    drain("rand");
    check_order("rand");
    check("wrap_cnt", cnt, 32'(5 % (1 << CW)));
    check("rand_seq", seq_err, 0);
    check("rand_gap_min", 32'(min_gap >= GAP + 1), 1);
    rand_busy = 1'b0;

    // timeout: TX never answers
    do_reset();
    tx_ack = 1'b0;
    push(8'($urandom));
    push(8'($urandom));
    drain("tmo");
    check("tmo_err", err, 1);
    check("tmo_delay", err_rise - first_valid, ACK);
    check("tmo_pops", pops, 2);
    check("tmo_cnt", cnt, 0);
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    check("tmo_clr", err, 0);
    tx_ack = 1'b1;

    // EN drop during WAIT_DONE
    do_reset();
    busy_len = 10;
    push(8'($urandom));
    push(8'($urandom));
    push(8'($urandom));
    n = 0;
    while (!bus.TX_BUSY && n < 50) begin
      tick();
      n++;
    end
    check("endrop_bound", 32'(n < 50), 1);
    EN = 1'b0;
    repeat (30) tick();
    check("endrop_pops", pops, 1);
    check("endrop_cnt", cnt, 1);
    check("endrop_left", fifo_q.size(), 2);
    EN = 1'b1;
    drain("resume");
    check("resume_pops", pops, 3);
    check("resume_cnt", cnt, 3);
    check_order("resume");

    // reset while waiting for ack
    do_reset();
    tx_ack = 1'b0;
    push(8'($urandom));
    n = 0;
    while (first_valid < 0 && n < 50) begin
      tick();
      n++;
    end
    check("midrst_bound", 32'(n < 50), 1);
    repeat (2) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("midrst_rinc", bus.FIFO_R_INC, 0);
    check("midrst_valid", bus.TX_DATA_VALID, 0);
    check("midrst_pdata", bus.TX_P_DATA, 0);
    check("midrst_err", err, 0);
    check("midrst_cnt", cnt, 0);
    repeat (20) tick();
    check("midrst_err_after", err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
